// File: rtl/minx_pkg.sv
// Shared definitions for the EEPROM (I2C-style) bus master: register map,
// CTRL bit positions, sequencer state encoding and the phase-order helper.
package minx_pkg;

    localparam logic [23:0] ADDR_CTRL   = 24'h002068;
    localparam logic [23:0] ADDR_DATA   = 24'h002069;
    localparam logic [23:0] ADDR_STATUS = 24'h00206A;
    localparam logic [23:0] ADDR_DIV    = 24'h00206B;

    localparam int CTRL_START  = 0;
    localparam int CTRL_WRITE  = 1;
    localparam int CTRL_READ   = 2;
    localparam int CTRL_STOP   = 3;
    localparam int CTRL_RXNACK = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_STOP
    } state_e;

    // Phase that follows 'cur' for a given command; disabled phases are skipped.
    function automatic state_e next_phase(state_e cur, logic [4:0] cmd);
        state_e nxt;
        nxt = ST_IDLE;
        case (cur)
            ST_IDLE: begin
                if (cmd[CTRL_START])                        nxt = ST_START;
                else if (cmd[CTRL_WRITE] || cmd[CTRL_READ]) nxt = ST_BYTE;
                else if (cmd[CTRL_STOP])                    nxt = ST_STOP;
            end
            ST_START: begin
                if (cmd[CTRL_WRITE] || cmd[CTRL_READ]) nxt = ST_BYTE;
                else if (cmd[CTRL_STOP])               nxt = ST_STOP;
            end
            ST_BYTE:  if (cmd[CTRL_STOP]) nxt = ST_STOP;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quarter_tick.sv
// Quarter-period timebase: one-clock tick every div+1 clocks while enabled,
// reloaded by restart so every command begins on a full quarter.
module quarter_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart)
            cnt_d = div;
        else if (en)
            cnt_d = (cnt_q == 8'd0) ? div : cnt_q - 8'd1;
    end

    assign tick = en && !restart && (cnt_q == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/eeprom_master.sv
// EEPROM bus master: CPU register block plus START/BYTE/STOP sequencer driving
// open-drain SCL/SDA. Define EEPROM_MASTER_IRQ_EN to enable the completion IRQ.
module eeprom_master
    import minx_pkg::*;
#(
    parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        scl_out,
    output logic        sda_out,
    input  logic        sda_in,
    output logic        irq
);

    state_e     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [3:0] bit_q, bit_d;
    logic [4:0] cmd_q, cmd_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d, div_q, div_d;
    logic       nack_q, nack_d, scl_q, scl_d, sda_q, sda_d, irq_q;
    logic       busy, tick, launch, bit_val;
    logic       wr_ctrl, wr_data, wr_status, wr_div;
    logic [2:0] tx_idx;

    assign busy      = (state_q != ST_IDLE);
    assign wr_ctrl   = bus_write && (bus_address_in == ADDR_CTRL);
    assign wr_data   = bus_write && (bus_address_in == ADDR_DATA);
    assign wr_status = bus_write && (bus_address_in == ADDR_STATUS);
    assign wr_div    = bus_write && (bus_address_in == ADDR_DIV);
    assign launch    = wr_ctrl && !busy && (bus_data_in[3:0] != 4'd0);

    quarter_tick u_quarter_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (launch),
        .en      (busy),
        .div     (div_q),
        .tick    (tick)
    );

    // Sequencer: quarter / bit position and phase order.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        if (launch) begin
            cmd_d = bus_data_in[4:0];
            if (bus_data_in[CTRL_WRITE]) cmd_d[CTRL_READ] = 1'b0;
            state_d = next_phase(ST_IDLE, cmd_d);
            qtr_d   = 2'd0;
            bit_d   = 4'd0;
        end else if (tick) begin
            if (qtr_q != 2'd3) begin
                qtr_d = qtr_q + 2'd1;
            end else begin
                qtr_d = 2'd0;
                if (state_q == ST_BYTE && bit_q != 4'd8) begin
                    bit_d = bit_q + 4'd1;
                end else begin
                    state_d = next_phase(state_q, cmd_q);
                    bit_d   = 4'd0;
                end
            end
        end
    end

    // Line levels are loaded at the start of each quarter and held in IDLE,
    // so a command without STOP leaves SCL low and the bus owned.
    always_comb begin
        scl_d  = scl_q;
        sda_d  = sda_q;
        tx_idx = 3'd7 - bit_d[2:0];
        if (bit_d == 4'd8) bit_val = cmd_d[CTRL_WRITE] ? 1'b1 : cmd_d[CTRL_RXNACK];
        else               bit_val = cmd_d[CTRL_WRITE] ? tx_q[tx_idx] : 1'b1;
        if (launch || tick) begin
            case (state_d)
                ST_START: begin
                    case (qtr_d)
                        2'd0:    sda_d = 1'b1;
                        2'd1:    begin scl_d = 1'b1; sda_d = 1'b1; end
                        2'd2:    begin scl_d = 1'b1; sda_d = 1'b0; end
                        default: begin scl_d = 1'b0; sda_d = 1'b0; end
                    endcase
                end
                ST_BYTE: begin
                    scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                    sda_d = bit_val;
                end
                ST_STOP: begin
                    case (qtr_d)
                        2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
                        2'd1:    begin scl_d = 1'b1; sda_d = 1'b0; end
                        default: begin scl_d = 1'b1; sda_d = 1'b1; end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_d   = tx_q;
        rx_d   = rx_q;
        div_d  = div_q;
        nack_d = nack_q;
        if (!busy && wr_data) tx_d  = bus_data_in;
        if (!busy && wr_div)  div_d = bus_data_in;
        if (wr_status && bus_data_in[1]) nack_d = 1'b0;
        // SDA is sampled on the last clock of Q2 of every bit.
        if (tick && state_q == ST_BYTE && qtr_q == 2'd2) begin
            if (bit_q == 4'd8) begin
                if (cmd_q[CTRL_WRITE]) nack_d = sda_in;
            end else if (cmd_q[CTRL_READ]) begin
                rx_d = {rx_q[6:0], sda_in};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            qtr_q   <= 2'd0;
            bit_q   <= 4'd0;
            cmd_q   <= 5'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            div_q   <= DEFAULT_DIV;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            nack_q  <= nack_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

`ifdef EEPROM_MASTER_IRQ_EN
    logic irq_d, cmd_done;
    assign cmd_done = tick && (state_d == ST_IDLE);

    // Completion wins over a same-clock W1C.
    always_comb begin
        irq_d = irq_q;
        if (wr_status && bus_data_in[2]) irq_d = 1'b0;
        if (cmd_done)                    irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end
`else
    assign irq_q = 1'b0;
`endif

    always_comb begin
        bus_data_out = 8'h00;
        if (bus_read) begin
            case (bus_address_in)
                ADDR_DATA:   bus_data_out = rx_q;
                ADDR_STATUS: bus_data_out = {5'b0, irq_q, nack_q, busy};
                ADDR_DIV:    bus_data_out = div_q;
                default:     bus_data_out = 8'h00;
            endcase
        end
    end

    assign scl_out = scl_q;
    assign sda_out = sda_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_eeprom_master.sv
// Self-checking bench for eeprom_master: directed corner cases plus random
// commands checked against a transaction-level model of the bus master.
module tb_eeprom_master;

    localparam logic [23:0] A_CTRL   = 24'h002068;
    localparam logic [23:0] A_DATA   = 24'h002069;
    localparam logic [23:0] A_STATUS = 24'h00206A;
    localparam logic [23:0] A_DIV    = 24'h00206B;
`ifdef EEPROM_MASTER_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, bus_write, bus_read, sda_in;
    logic [23:0] addr;
    logic [7:0]  din, dout;
    logic        scl_out, sda_out, irq;

    eeprom_master dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (addr),
        .bus_data_in    (din),
        .bus_data_out   (dout),
        .scl_out        (scl_out),
        .sda_out        (sda_out),
        .sda_in         (sda_in),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state of the software-visible registers.
    logic [7:0] m_tx, m_rx, m_div;
    logic       m_nack;

    // Slave model: on every SCL rise of the byte, record SDA and present the
    // next slave bit; bits outside the byte are released.
    logic       mon_on = 1'b0;
    int         rise_cnt, skip;
    logic [8:0] slave_bits, obs_sda;
    logic       scl_prev = 1'b1;

    always @(negedge clk) begin : mon
        int k;
        if (!mon_on) begin
            rise_cnt = 0;
            obs_sda  = 'x;
            sda_in   = 1'b1;
        end else if (scl_out && !scl_prev) begin
            k = rise_cnt - skip;
            if (k >= 0 && k <= 8) begin
                obs_sda[k] = sda_out;
                sda_in     = slave_bits[k];
            end else begin
                sda_in = 1'b1;
            end
            rise_cnt++;
        end
        scl_prev = scl_out;
    end

    task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; bus_read = 1'b1;
        #1 d = dout;
        bus_read = 1'b0;
    endtask

    task automatic setup_cmd(input logic [7:0] div, input logic [7:0] ctrl, input logic wr_tx,
                             input logic [7:0] tx, input logic [7:0] slave, input logic ack);
        bus_wr(A_DIV, div);
        m_div = div;
        if (wr_tx) begin
            bus_wr(A_DATA, tx);
            m_tx = tx;
        end
        @(negedge clk);
        skip = (ctrl[0] && !scl_out) ? 1 : 0;
        for (int k = 0; k < 8; k++)
            slave_bits[k] = ctrl[1] ? 1'b1 : slave[7-k];
        slave_bits[8] = ctrl[1] ? ack : 1'b1;
        mon_on = 1'b1;
        bus_wr(A_CTRL, ctrl);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] div, input logic [7:0] ctrl,
                           input logic wr_tx, input logic [7:0] tx, input logic [7:0] slave,
                           input logic ack, input int inject_at);
        int         n, quarters;
        logic       is_wr, is_rd, done;
        logic [7:0] rd;
        logic [8:0] exp_sda;
        setup_cmd(div, ctrl, wr_tx, tx, slave, ack);
        is_wr = ctrl[1];
        is_rd = ctrl[2] && !ctrl[1];
        quarters = 4 * int'(ctrl[0]) + 36 * int'(is_wr || is_rd) + 4 * int'(ctrl[3]);

        n = 0; done = 1'b0;
        addr = A_STATUS; bus_read = 1'b1;
        while (!done) begin
            #1;
            if (!dout[0] || n > 6000) begin
                done = 1'b1;
            end else begin
                n++;
                if (n == inject_at) begin
                    bus_read = 1'b0;
                    for (int j = 0; j < 3; j++) begin
                        addr = (j == 0) ? A_CTRL : (j == 1) ? A_DATA : A_DIV;
                        din  = (j == 0) ? 8'h02  : (j == 1) ? 8'h55  : 8'h07;
                        bus_write = 1'b1;
                        @(negedge clk);
                    end
                    n += 2;
                    bus_write = 1'b0; addr = A_STATUS; bus_read = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        bus_read = 1'b0;
        chk({tag, "_busy_clks"}, n, quarters * (int'(div) + 1));

        if (is_wr || is_rd) begin
            for (int k = 0; k < 8; k++) exp_sda[k] = is_wr ? m_tx[7-k] : 1'b1;
            exp_sda[8] = is_wr ? 1'b1 : ctrl[4];
            chk({tag, "_sda_bits"}, obs_sda, exp_sda);
        end
        if (is_rd) m_rx = slave;
        if (is_wr) m_nack = ack;

        if (ctrl[3]) chk({tag, "_bus_lines"}, {scl_out, sda_out}, 2'b11);
        else         chk({tag, "_scl_held"}, scl_out, 1'b0);
        bus_rd(A_DATA, rd);
        chk({tag, "_rx"}, rd, m_rx);
        bus_rd(A_STATUS, rd);
        chk({tag, "_status"}, rd, {5'b0, IRQ_EN, m_nack, 1'b0});
        chk({tag, "_irq"}, irq, IRQ_EN);
        bus_wr(A_STATUS, 8'h04);
        chk({tag, "_irq_clr"}, irq, 1'b0);
        mon_on = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        reset = 1'b0; bus_write = 1'b0; bus_read = 1'b0; addr = '0; din = '0;
        m_tx = 8'h00; m_rx = 8'h00; m_div = 8'd3; m_nack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        chk("rst_lines", {scl_out, sda_out, irq}, 3'b110);
        bus_rd(A_STATUS, rd); chk("rst_status", rd, 8'h00);
        bus_rd(A_DIV, rd);    chk("rst_div", rd, 8'd3);
        bus_rd(A_DATA, rd);   chk("rst_rx", rd, 8'h00);

        run_cmd("wr_div0", 8'd0, 8'h0B, 1'b1, 8'hA0, 8'h00, 1'b0, -1);
        run_cmd("rd_div3", 8'd3, 8'h04, 1'b0, 8'h00, 8'h5A, 1'b1, -1);
        run_cmd("wr_nack", 8'd1, 8'h0A, 1'b1, 8'hC3, 8'h00, 1'b1, -1);

        run_cmd("busy_ign", 8'd2, 8'h0B, 1'b1, 8'h3C, 8'h00, 1'b0, 10);
        bus_rd(A_DIV, rd); chk("busy_div_kept", rd, m_div);
        run_cmd("tx_kept", 8'd2, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0, -1);

        @(negedge clk); addr = 24'h002070; bus_read = 1'b1;
        #1 chk("rd_unmapped", dout, 8'h00);
        addr = A_CTRL; #1 chk("rd_ctrl", dout, 8'h00);
        bus_read = 1'b0; addr = A_DIV; #1 chk("rd_no_strobe", dout, 8'h00);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            c = 8'($urandom_range(1, 31));
            if (c[3:0] == 4'd0) c[0] = 1'b1;
            run_cmd($sformatf("rnd%0d", i), 8'($urandom_range(0, 3)), c, 1'b1,
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of bit 5 of a write.
        setup_cmd(8'd3, 8'h0B, 1'b1, 8'h96, 8'h00, 1'b0);
        for (int i = 0; i < 3000 && (rise_cnt - skip) < 6; i++) @(negedge clk);
        chk("mid_reached_bit5", rise_cnt - skip, 6);
        reset = 1'b0;
        #1 chk("mid_rst_lines", {scl_out, sda_out, irq}, 3'b110);
        addr = A_STATUS; bus_read = 1'b1;
        #1 chk("mid_rst_status", dout, 8'h00);
        addr = A_DIV;
        #1 chk("mid_rst_div", dout, 8'd3);
        bus_read = 1'b0; mon_on = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_tx = 8'h00; m_rx = 8'h00; m_div = 8'd3; m_nack = 1'b0;
        bus_rd(A_DATA, rd); chk("post_rst_rx", rd, 8'h00);
        run_cmd("post_rst", 8'd0, 8'h0B, 1'b0, 8'h00, 8'h00, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_master.md
EEPROM_MASTER -- requirements
Module: eeprom_master

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 8'd3: reset value of the DIV register.
REQ-002 SHALL have port clk  input  1: single system clock; all state on posedge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-004 SHALL have ports bus_write, bus_read  input  1 each: CPU bus strobes.
REQ-005 SHALL have ports bus_address_in  input  24 and bus_data_in  input  8: CPU bus address and write data.
REQ-006 SHALL have port bus_data_out  output  8: read data, 8'h00 unless a read targets 0x2068-0x206B (OR-merged bus).
REQ-007 SHALL have ports scl_out, sda_out  output  1 each: open-drain line drivers, 1 = release, 0 = pull low.
REQ-008 SHALL have port sda_in  input  1: sampled SDA line level.
REQ-009 SHALL have port irq  output  1: command-complete interrupt level.

Function
REQ-010 SHALL decode the registers CTRL 0x2068 (W), DATA 0x2069 (W = TX, R = RX), STATUS 0x206A (R, W1C), and DIV 0x206B (R/W).
REQ-011 SHALL interpret CTRL bits as follows: [0] START, [1] WRITE, [2] READ, [3] STOP, [4] RXNACK (level sent after a read byte); a CTRL write with any of bits [3:0] set launches a command.
REQ-012 SHALL execute the phases of a command in fixed order START -> WRITE|READ -> STOP, skipping any phase whose bit is clear; if WRITE and READ are both set, WRITE SHALL win.
REQ-013 SHALL define a quarter-period as DIV+1 clocks; with DIV=0 a quarter is 1 clock.
REQ-014 SHALL run START over 4 quarters: release SDA, release SCL, SDA low, SCL low.
REQ-015 SHALL run STOP over 4 quarters: SDA low, release SCL, release SDA, idle.
REQ-016 SHALL run each bit over 4 quarters: Q0 SCL low and drive SDA; Q1 release SCL; Q2 sample sda_in at the last clock of Q2; Q3 SCL low.
REQ-017 SHALL transfer a byte as 8 bits MSB first plus a 9th ACK bit: 36 quarters.
REQ-018 SHALL, on WRITE, release SDA for the ACK bit and latch the sampled level into STATUS[1] NACK.
REQ-019 SHALL, on READ, release SDA for the data bits, shift the samples into RX, and drive RXNACK on the ACK bit.
REQ-020 SHALL implement the state machine IDLE -> START -> BYTE -> STOP -> IDLE, with skipped phases passing straight through.
REQ-021 SHALL set STATUS[0] BUSY on the clock after the launching CTRL write and clear it on the clock the last phase ends.
REQ-022 SHALL ignore CTRL, DATA and DIV writes while BUSY and leave TX unchanged.
REQ-023 SHALL, on a DIV change, take effect at the next command.
REQ-024 SHALL keep the bus released (scl_out=1, sda_out=1) while in IDLE after STOP; without STOP, SCL SHALL stay low and the bus SHALL be held.
REQ-025 SHALL return {5'b0, IRQ, NACK, BUSY} on a STATUS read.

Reset
REQ-026 SHALL drive state IDLE, scl_out=1, sda_out=1, irq=0, STATUS=0, TX=RX=8'h00, DIV=DEFAULT_DIV while reset is asserted, including mid-command, with no STOP generated.

Configuration
REQ-027 SHALL, with EEPROM_MASTER_IRQ_EN defined, set STATUS[2] IRQ at command end and drive irq = STATUS[2]; writing STATUS with bit2=1 SHALL clear it, and simultaneous set and clear SHALL resolve to set.
REQ-028 SHALL, with EEPROM_MASTER_IRQ_EN undefined, tie irq to 0 and read STATUS[2] as 0.

Structure
REQ-029 SHALL place the register addresses, CTRL bit indices and the state enum in the shared package minx_pkg.
REQ-030 SHALL contain one sub-module, quarter_tick: a down-counter that emits a 1-clock tick every DIV+1 clocks, restarted at command launch.

Verification
REQ-031 SHALL cover: DIV=0, DATA=0xA0, CTRL=0x0B, sda_in=0 on ACK -> BUSY for 44 clocks, SDA bit pattern 1010_0000, NACK=0, bus released at end.
REQ-032 SHALL cover: DIV=3, CTRL=0x04, sda_in pattern 0x5A, RXNACK=0 -> 36 quarters x 4 clocks = 144 BUSY clocks, DATA read = 0x5A, SDA low on the 9th bit.
REQ-033 SHALL cover: WRITE with sda_in=1 on ACK -> NACK=1; irq=1 when EEPROM_MASTER_IRQ_EN is defined; a STATUS write of 0x04 clears irq next clock.
REQ-034 SHALL cover: a CTRL write of 0x02 while BUSY -> ignored, TX unchanged, completion time unchanged.
REQ-035 SHALL cover: reset asserted during bit 5 of a write -> scl_out=sda_out=1 immediately and STATUS=0.
REQ-036 SHALL cover: a read of 0x2070 or of any register with bus_read low -> bus_data_out = 8'h00.
